p405s_mac_addopnd_seq: RTL and testbench
========================================

P405S_MAC_ADDOPND_SEQ -- requirements
Module: p405s_mac_addopnd_seq

Interface
REQ-001 Parameters: none; the datapath width SHALL be fixed at 32 bits and the carry-predict width at 8 bits.
REQ-002 The ports SHALL be as follows:
- CB  in  1  clock; all state SHALL update on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VLD  in  1  operation request valid.
- REQ_RDY  out  1  block accepts a request this cycle.
- REQ_OP  in  1  0=ADD, 1=MAC.
- REQ_X  in  32  ADD: operand A; MAC: multiplier sum vector.
- REQ_Y  in  32  ADD: operand B; MAC: multiplier carry vector.
- ACC_CLR  in  1  synchronous accumulator clear.
- ADD_A  out  32  registered operand A to the 32-bit carry-predict adder.
- ADD_B  out  32  registered operand B to the adder.
- ADD_SUM  in  32  adder sum, combinational from ADD_A/ADD_B.
- ADD_CP  in  8  adder group carries, combinational.
- RES_VLD  out  1  result valid.
- RES_RDY  in  1  consumer accepts the result.
- RES_SUM  out  32  registered result.
- RES_CP  out  8  registered carries of the final pass.
- ACC  out  32  accumulator contents.
- BUSY  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, P1, P2 and HOLD.
REQ-004 REQ_RDY SHALL be 1 only in IDLE; a request SHALL be accepted when REQ_VLD and REQ_RDY are both 1.
REQ-005 On acceptance, the block SHALL load ADD_A=REQ_X and ADD_B=REQ_Y and enter P1 (the cycle after the accepting edge is cycle 1).
REQ-006 P1 for ADD: the block SHALL capture RES_SUM=ADD_SUM and RES_CP=ADD_CP and enter HOLD; RES_VLD SHALL be 1 in cycle 2 (latency 2).
REQ-007 P1 for MAC: the block SHALL load ADD_A=ADD_SUM (the product) and ADD_B=ACC, then enter P2.
REQ-008 P2: the block SHALL capture RES_SUM=ADD_SUM, RES_CP=ADD_CP and ACC=ADD_SUM, then enter HOLD; RES_VLD SHALL be 1 in cycle 3 (latency 3).
REQ-009 HOLD:
- RES_VLD SHALL be 1.
- RES_SUM and RES_CP SHALL be stable until RES_RDY=1.
- On RES_RDY=1 the block SHALL enter IDLE, with RES_VLD=0 the next cycle.
REQ-010 There SHALL be no request/result overlap; the minimum spacing between requests SHALL be 3 cycles (ADD) or 4 cycles (MAC), including the accept cycle.
REQ-011 All sums SHALL be modulo 2^32; carry-out of bit 31 SHALL be discarded with no overflow flag; RES_CP SHALL pass ADD_CP unmodified.
REQ-012 ADD SHALL never modify ACC.
REQ-013 ACC_CLR=1 SHALL clear ACC to 0 on the next edge in any state.
REQ-014 ACC_CLR in P1 of a MAC SHALL cause pass 2 to use B=0.
REQ-015 ACC_CLR coincident with the P2 capture SHALL take priority, leaving ACC=0 while RES_SUM still holds the P2 sum.
REQ-016 ADD_A and ADD_B SHALL hold their last values in IDLE and HOLD.
REQ-017 REQ_X, REQ_Y and REQ_OP SHALL be ignored outside the accept cycle.

Reset
REQ-018 RST_N=0 SHALL immediately force:
- state=IDLE, REQ_RDY=1, RES_VLD=0, BUSY=0;
- RES_SUM=0, RES_CP=0, ACC=0, ADD_A=0, ADD_B=0.
REQ-019 Reset mid-operation (P1, P2 or HOLD) SHALL abandon the operation with no result delivered.
REQ-020 The first request SHALL be accepted on the first rising edge with RST_N=1.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- ADD X=0x0000_03FF, Y=0x0000_0001, RES_RDY=1 -> RES_VLD in cycle 2, RES_SUM=0x0000_0400, RES_CP=0x00, ACC unchanged.
- Reset, then MAC X=0x10, Y=0x20 -> cycle 3 RES_SUM=0x30, ACC=0x30; a second MAC X=0x10, Y=0x20 -> RES_SUM=0x60, ACC=0x60.
- ADD X=0xFFFF_FFFF, Y=0x1 -> RES_SUM=0x0, RES_CP=0xFF, no flag.
- Result with RES_RDY held 0 for 5 cycles -> RES_VLD and RES_SUM stable, REQ_RDY=0 throughout; IDLE one cycle after RES_RDY=1.
- ACC=0x100, then MAC X=0x5, Y=0x0 with ACC_CLR pulsed in P1 -> RES_SUM=0x5, ACC=0x5.
- RST_N pulsed low in P2 -> outputs zero asynchronously, no RES_VLD, next request accepted normally.

Source files
------------

// File: rtl/p405s_mac_addopnd_seq.sv
// Operand sequencer for the MAC/ADD path. It drives a shared 32-bit carry-predict adder.
// An ADD takes one pass through the adder; a MAC takes two, and the second pass adds the accumulator.
module p405s_mac_addopnd_seq (
    input  logic        cb,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_op,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic        acc_clr,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic [7:0]  add_cp,
    output logic        res_vld,
    input  logic        res_rdy,
    output logic [31:0] res_sum,
    output logic [7:0]  res_cp,
    output logic [31:0] acc,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a request, req_rdy high
    // P1    | first adder pass (ADD result, or MAC product reduction)
    // P2    | MAC second pass: product + accumulator
    // HOLD  | result presented until res_rdy
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;

    state_t state;
    logic   op;

    always_ff @(posedge cb or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= OP_ADD;
            add_a   <= '0;
            add_b   <= '0;
            res_sum <= '0;
            res_cp  <= '0;
            acc     <= '0;
            req_rdy <= 1'b1;
            res_vld <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (acc_clr)
                acc <= '0;
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        add_a   <= req_x;
                        add_b   <= req_y;
                        op      <= req_op;
                        state   <= P1;
                        req_rdy <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                P1: begin
                    if (op == OP_ADD) begin
                        res_sum <= add_sum;
                        res_cp  <= add_cp;
                        res_vld <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        // A clear landing here must also zero the second-pass addend.
                        add_a <= add_sum;
                        add_b <= acc_clr ? 32'd0 : acc;
                        state <= P2;
                    end
                end
                P2: begin
                    res_sum <= add_sum;
                    res_cp  <= add_cp;
                    if (!acc_clr)
                        acc <= add_sum;
                    res_vld <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        busy    <= 1'b0;
                        req_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    res_vld <= 1'b0;
                    busy    <= 1'b0;
                    req_rdy <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_mac_addopnd_seq.sv
// Bench for p405s_mac_addopnd_seq: a behavioural adder stand-in plus a transaction-level result/accumulator model.
// It runs directed corner cases, then randomized ADD/MAC traffic.
module tb_p405s_mac_addopnd_seq;

    logic        cb = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy, req_op;
    logic [31:0] req_x, req_y;
    logic        acc_clr;
    logic [31:0] add_a, add_b, add_sum;
    logic [7:0]  add_cp;
    logic        res_vld, res_rdy;
    logic [31:0] res_sum;
    logic [7:0]  res_cp;
    logic [31:0] acc;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] acc_m = 32'd0;

    always #5 cb = ~cb;

    p405s_mac_addopnd_seq dut (
        .cb(cb), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .acc_clr(acc_clr), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_cp(add_cp), .res_vld(res_vld), .res_rdy(res_rdy),
        .res_sum(res_sum), .res_cp(res_cp), .acc(acc), .busy(busy)
    );

    // Adder stand-in: every cp bit carries the bit-31 carry-out, XORed with the AND of the top operand bytes.
    function automatic logic [7:0] cp_fn(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {8{s[32]}} ^ (a[31:24] & b[31:24]);
    endfunction

    assign add_sum = add_a + add_b;
    assign add_cp  = cp_fn(add_a, add_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Issues one request and plays it through to IDLE.
    task automatic do_op(input logic op, input logic [31:0] x, input logic [31:0] y,
                         input int hold, input logic clr_p1, input logic clr_p2);
        logic [31:0] e_sum, e_a, e_b, prod;
        logic [7:0]  e_cp;
        if (op == 1'b0) begin
            e_sum = x + y;
            e_cp  = cp_fn(x, y);
            e_a   = x;
            e_b   = y;
            if (clr_p1) acc_m = 32'd0;
        end else begin
            prod  = x + y;
            e_b   = clr_p1 ? 32'd0 : acc_m;
            e_a   = prod;
            e_sum = prod + e_b;
            e_cp  = cp_fn(prod, e_b);
            acc_m = clr_p2 ? 32'd0 : e_sum;
        end
        chk("req_rdy_idle", {31'd0, req_rdy}, 32'd1);
        req_vld = 1'b1; req_op = op; req_x = x; req_y = y;
        res_rdy = 1'b0;
        @(posedge cb);
        @(negedge cb);
        req_vld = 1'b0; req_op = ~op; req_x = $urandom; req_y = $urandom;
        chk("c1_res_vld", {31'd0, res_vld}, 32'd0);
        chk("c1_busy", {31'd0, busy}, 32'd1);
        chk("c1_add_a", add_a, x);
        chk("c1_add_b", add_b, y);
        acc_clr = clr_p1;
        if (op == 1'b1) begin
            @(negedge cb);
            acc_clr = clr_p2;
            chk("c2_res_vld", {31'd0, res_vld}, 32'd0);
            chk("c2_add_a", add_a, prod);
            chk("c2_add_b", add_b, e_b);
        end
        @(negedge cb);
        acc_clr = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            chk("res_vld", {31'd0, res_vld}, 32'd1);
            chk("res_sum", res_sum, e_sum);
            chk("res_cp", {24'd0, res_cp}, {24'd0, e_cp});
            chk("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
            chk("hold_add_a", add_a, e_a);
            chk("acc", acc, acc_m);
            if (i == hold) res_rdy = 1'b1;
            @(negedge cb);
        end
        res_rdy = 1'b0;
        chk("post_res_vld", {31'd0, res_vld}, 32'd0);
        chk("post_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        acc_m = 32'd0;
        @(negedge cb);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_vld = 1'b0; req_op = 1'b0; req_x = '0; req_y = '0;
        acc_clr = 1'b0; res_rdy = 1'b0;
        @(negedge cb);
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rst_res_vld", {31'd0, res_vld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_sum", res_sum, 32'd0);
        chk("rst_res_cp", {24'd0, res_cp}, 32'd0);
        chk("rst_acc", acc, 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        @(negedge cb);
        rst_n = 1'b1;

        do_op(1'b0, 32'h0000_03FF, 32'h0000_0001, 0, 1'b0, 1'b0);
        chk("d1_sum_const", res_sum, 32'h0000_0400);

        pulse_reset();
        do_op(1'b1, 32'h10, 32'h20, 0, 1'b0, 1'b0);
        chk("d2_acc_30", acc, 32'h30);
        do_op(1'b1, 32'h10, 32'h20, 0, 1'b0, 1'b0);
        chk("d2_acc_60", acc, 32'h60);

        do_op(1'b0, 32'hFFFF_FFFF, 32'h1, 0, 1'b0, 1'b0);
        chk("d3_cp_ff", {24'd0, res_cp}, 32'hFF);
        chk("d3_acc_kept", acc, 32'h60);

        do_op(1'b0, 32'h1234_5678, 32'h1111_1111, 5, 1'b0, 1'b0);

        acc_clr = 1'b1;
        acc_m = 32'd0;
        @(negedge cb);
        acc_clr = 1'b0;
        chk("idle_clr", acc, 32'd0);
        do_op(1'b1, 32'h80, 32'h80, 0, 1'b0, 1'b0);
        chk("d5_acc_100", acc, 32'h100);
        do_op(1'b1, 32'h5, 32'h0, 0, 1'b1, 1'b0);
        chk("d5_acc_5", acc, 32'h5);

        do_op(1'b1, 32'h7, 32'h9, 1, 1'b0, 1'b1);
        chk("p2_clr_acc", acc, 32'd0);

        // Reset dropped while the MAC is in its second pass.
        req_vld = 1'b1; req_op = 1'b1; req_x = 32'h33; req_y = 32'h44;
        @(posedge cb);
        @(negedge cb);
        req_vld = 1'b0;
        @(negedge cb);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res_vld", {31'd0, res_vld}, 32'd0);
        chk("arst_res_sum", res_sum, 32'd0);
        chk("arst_acc", acc, 32'd0);
        chk("arst_add_a", add_a, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_req_rdy", {31'd0, req_rdy}, 32'd1);
        acc_m = 32'd0;
        @(negedge cb);
        rst_n = 1'b1;
        @(negedge cb);
        chk("arst_no_result", {31'd0, res_vld}, 32'd0);
        do_op(1'b1, 32'h2, 32'h3, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic        op, c1, c2;
            logic [31:0] x, y;
            op = 1'($urandom_range(0, 1));
            x  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            c1 = op && ($urandom_range(0, 3) == 0);
            c2 = op && !c1 && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                acc_clr = 1'b1;
                acc_m = 32'd0;
                @(negedge cb);
                acc_clr = 1'b0;
                chk("rnd_idle_clr", acc, 32'd0);
            end
            do_op(op, x, y, int'($urandom_range(0, 3)), c1, c2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
